decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
- Parametrised successor to the combinational instruction decoder.
- A DEPTH-entry {pc, inst} FIFO sits between fetch and the ID/EX boundary, followed by a registered decode stage.
- Provides valid/ready handshakes on both sides, a branch flush, and a WFI sleep state that holds issue until an interrupt is pending.
- Lets fetch run ahead of back-end stalls (D_core_wait and load-use stall map onto out_ready = 0).

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥ 2.
- XLEN, 32, PC width.
- PTR_W, $clog2(DEPTH), FIFO pointer width (derived).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  branch/jump redirect; discards all queued and staged instructions.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept this cycle.
- in_pc  in  XLEN  PC of the incoming instruction.
- in_inst  in  32  incoming instruction word.
- out_valid  out  1  staged decoded instruction is valid.
- out_ready  in  1  downstream accepts the staged instruction.
- out_pc  out  XLEN  staged PC.
- out_inst  out  32  staged instruction word.
- out_ctrl  out  12  decoded controls, {NOP, CSR_inst, MRET, WFI, Branch, JAL, JALR, MemRead, MemWrite, RegWrite, ALUSrc, PCtoReg}.
- out_aluop  out  2  {R-type, I-type} ALU operation class.
- irq_pending  in  1  level interrupt-pending indication; wakes the block from SLEEP.
- wfi_sleep  out  1  high while in SLEEP.
- count  out  PTR_W+1  current FIFO occupancy (excludes the staged entry).

Behaviour:
- Reset (rst_n = 0 at an edge): rd/wr pointers = 0, count = 0, out_valid = 0, out_pc/out_inst/out_ctrl/out_aluop = 0, state = RUN, wfi_sleep = 0.
- in_ready = (count != DEPTH) & ~flush. Combinational; does not depend on a same-cycle pop.
- Push occurs when in_valid & in_ready: write the entry at wr_ptr, wr_ptr++ (wraps modulo DEPTH), count++.
- Load condition: state == RUN & count != 0 & (~out_valid | out_ready) & ~flush.
  - On load: pop the head into the out registers, rd_ptr++ (wraps), count--.
  - Push and pop in the same cycle leave count unchanged.
- Retire without reload: if out_valid & out_ready and no load occurs, out_valid → 0.
- Latency: a push at edge E gives out_valid = 1 after edge E+1, provided the stage is free and state is RUN. There is no combinational bypass.
- Holding: while out_valid & ~out_ready, out_pc, out_inst, out_ctrl and out_aluop are held stable.
- Decoding is computed from the popped word and registered with it; out_ctrl and out_aluop are 0 whenever out_valid = 0. Field equations (op = inst[6:0]):
  - NOP: op == 0.
  - Branch: op[6:4] == 110.
  - JAL: op == 1101111.
  - JALR: op == 1100111.
  - MemRead: op == 0000011.
  - MemWrite: op == 0100011.
  - ALUSrc: ~op[6] & ~(op[5] & op[4]).
  - aluop[1]: op[5] & op[4] & ~op[6].
  - aluop[0]: op[4] & ~op[5].
  - CSR_inst: op[6:4] == 111.
  - MRET: CSR_inst & inst[31:20] == 12'h302.
  - WFI: CSR_inst & inst[31:20] == 12'h105.
  - RegWrite: (~op[5] | op[4] | op[3] | op[2]) & ~MRET & ~WFI.
  - PCtoReg: JAL | JALR | AUIPC (0010111) | LUI (0110111).
- FSM has two states, RUN and SLEEP.
  - RUN → SLEEP when out_valid & out_ready & out_ctrl.WFI, unless irq_pending is already 1 that cycle (then stay in RUN).
  - SLEEP → RUN when irq_pending = 1 or flush = 1.
  - In SLEEP: no loads, pushes still accepted until full, wfi_sleep = 1.
- Flush (highest priority below reset):
  - At the edge: count = 0, pointers = 0, out_valid = 0, out_ctrl = 0, state = RUN.
  - A same-cycle push is dropped (in_ready is already 0).
  - A same-cycle out_valid & out_ready transfer is still considered taken by downstream.
- Full: count == DEPTH forces in_ready = 0 even if a pop occurs that cycle.
- Empty: with count == 0, out_valid falls after the staged entry retires.
- Reset mid-operation overrides flush, the FSM and all handshakes.

Test Plan:
- Reset/latency: rst_n = 0 for 2 cycles, then push inst 0x00500093 (addi) at pc 0x100 with out_ready = 1.
  - After reset: all outputs are 0.
  - out_valid = 1 exactly one cycle after the push edge, out_pc = 0x100, ALUSrc = 1, RegWrite = 1, aluop = 01.
- Fill/backpressure: out_ready = 0, push 6 instructions at DEPTH = 4 (the first is staged).
  - count reaches 4 and in_ready = 0; the 6th push stalls.
  - Then out_ready = 1: instructions emerge in push order with no loss and no duplication, and pointers wrap cleanly.
- Simultaneous push/pop: steady in_valid = out_ready = 1 for 20 cycles.
  - count stays constant and one instruction retires per cycle.
- Flush: with count = 3 and a staged beq (0x00208463), assert flush together with in_valid.
  - Next cycle: count = 0, out_valid = 0, and the pushed entry is absent.
- WFI: retire 0x10500073, with 2 entries queued behind it.
  - wfi_sleep = 1 and out_valid = 0 for 10 cycles.
  - Raise irq_pending: state returns to RUN and out_valid = 1 one cycle later.
  - Repeat with irq_pending already high at retire: no sleep.
- Decode sweep: one each of sw (0x0020a023) → MemWrite = 1, RegWrite = 0; lw → MemRead = 1; jal → JAL = 1, Branch = 1, PCtoReg = 1; mret (0x30200073) → MRET = 1, RegWrite = 0; lui → PCtoReg = 1; 0x00000000 → NOP = 1.

Source files
------------

// File: rtl/decode_queue.sv
// Instruction queue between fetch and the ID/EX boundary: a DEPTH-entry {pc, inst}
// FIFO feeding a registered decode stage, with branch flush and WFI sleep.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [31:0]      in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [31:0]      out_inst,
    output logic [11:0]      out_ctrl,
    output logic [1:0]       out_aluop,
    input  logic             irq_pending,
    output logic             wfi_sleep,
    output logic [PTR_W:0]   count
);

    typedef enum logic {ST_RUN, ST_SLEEP} state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam int CTRL_WFI = 8;

    // out_ctrl bit order: {NOP, CSR, MRET, WFI, Branch, JAL, JALR, MemRead, MemWrite, RegWrite, ALUSrc, PCtoReg}
    function automatic logic [13:0] decode_fn(input logic [6:0] op, input logic [11:0] f12);
        logic nop, csr, mret, wfi, branch, jal, jalr, mem_rd, mem_wr, reg_wr, alu_src, pc_to_reg;
        logic [1:0] aluop;
        nop       = (op == 7'b0000000);
        branch    = (op[6:4] == 3'b110);
        jal       = (op == 7'b1101111);
        jalr      = (op == 7'b1100111);
        mem_rd    = (op == 7'b0000011);
        mem_wr    = (op == 7'b0100011);
        alu_src   = ~op[6] & ~(op[5] & op[4]);
        aluop[1]  = op[5] & op[4] & ~op[6];
        aluop[0]  = op[4] & ~op[5];
        csr       = (op[6:4] == 3'b111);
        mret      = csr & (f12 == 12'h302);
        wfi       = csr & (f12 == 12'h105);
        reg_wr    = (~op[5] | op[4] | op[3] | op[2]) & ~mret & ~wfi;
        pc_to_reg = jal | jalr | (op == 7'b0010111) | (op == 7'b0110111);
        return {nop, csr, mret, wfi, branch, jal, jalr, mem_rd, mem_wr, reg_wr, alu_src, pc_to_reg, aluop};
    endfunction

    logic [XLEN-1:0] pc_mem_q   [DEPTH];
    logic [31:0]     inst_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_pc_q, out_pc_d;
    logic [31:0]      out_inst_q, out_inst_d;
    logic [11:0]      out_ctrl_q, out_ctrl_d;
    logic [1:0]       out_aluop_q, out_aluop_d;
    state_t           state_q, state_d;

    logic            push, load, retire;
    logic [31:0]     head_inst;
    logic [XLEN-1:0] head_pc;
    logic [13:0]     head_dec;

    assign in_ready  = (count_q != FULL_CNT) & ~flush;
    assign push      = in_valid & in_ready;
    assign load      = (state_q == ST_RUN) & (count_q != '0) & (~out_valid_q | out_ready) & ~flush;
    assign retire    = out_valid_q & out_ready;
    assign head_pc   = pc_mem_q[rd_ptr_q];
    assign head_inst = inst_mem_q[rd_ptr_q];
    assign head_dec  = decode_fn(head_inst[6:0], head_inst[31:20]);

    // NOTE: the storage array has no reset; count_q and out_valid_q gate every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= in_pc;
            inst_mem_q[wr_ptr_q] <= in_inst;
        end
    end

    always_comb begin
        // NOTE: every target gets a hold value first so no path can infer a latch.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        out_ctrl_d  = out_ctrl_q;
        out_aluop_d = out_aluop_q;
        state_d     = state_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;

        if (load) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            out_valid_d = 1'b1;
            out_pc_d    = head_pc;
            out_inst_d  = head_inst;
            out_ctrl_d  = head_dec[13:2];
            out_aluop_d = head_dec[1:0];
        end else if (retire) begin
            out_valid_d = 1'b0;
            out_ctrl_d  = '0;
            out_aluop_d = '0;
        end

        case ({push, load})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_RUN:   if (retire & out_ctrl_q[CTRL_WFI] & ~irq_pending) state_d = ST_SLEEP;
            ST_SLEEP: if (irq_pending | flush) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
            out_ctrl_d  = '0;
            out_aluop_d = '0;
            state_d     = ST_RUN;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_inst_q  <= '0;
            out_ctrl_q  <= '0;
            out_aluop_q <= '0;
            state_q     <= ST_RUN;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
            out_ctrl_q  <= out_ctrl_d;
            out_aluop_q <= out_aluop_d;
            state_q     <= state_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_inst  = out_inst_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_aluop = out_aluop_q;
    assign wfi_sleep = (state_q == ST_SLEEP);
    assign count     = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue at DEPTH=4: reset, latency, backpressure, streaming,
// flush, WFI sleep/wake and a decode sweep, all with hand-computed expectations.
module tb_decode_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [11:0] out_ctrl;
    logic [1:0]  out_aluop;
    logic        irq_pending = 1'b0;
    logic        wfi_sleep;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_WFI  = 32'h10500073;

    decode_queue #(.DEPTH(4), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_ctrl(out_ctrl), .out_aluop(out_aluop),
        .irq_pending(irq_pending), .wfi_sleep(wfi_sleep), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] fpc(input int i);
        return 32'h200 + 32'(4 * i);
    endfunction

    function automatic logic [31:0] finst(input int i);
        return 32'h00100093 + (32'(i) << 20);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        total++; if ({out_pc, out_inst} !== 64'h0) begin bad++; $display("FAIL reset_pc_inst: got %h %h want 0", out_pc, out_inst); end
        total++; if ({out_ctrl, out_aluop} !== 14'h0) begin bad++; $display("FAIL reset_ctrl: got %h %b want 0", out_ctrl, out_aluop); end
        total++; if (count !== 3'd0 || wfi_sleep !== 1'b0) begin bad++; $display("FAIL reset_count_sleep: got %0d %b want 0 0", count, wfi_sleep); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h100;
        in_inst   = I_ADDI;
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || count !== 3'd1) begin bad++; $display("FAIL lat_push_edge: got valid=%b count=%0d want 0 1", out_valid, count); end
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_inst !== I_ADDI) begin bad++; $display("FAIL lat_staged: got %b %h %h want 1 100 %h", out_valid, out_pc, out_inst, I_ADDI); end
        total++; if (out_ctrl !== 12'h006 || out_aluop !== 2'b01) begin bad++; $display("FAIL lat_decode: got %h %b want 006 01", out_ctrl, out_aluop); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL lat_count: got %0d want 0", count); end
        step();
        total++; if (out_valid !== 1'b0 || out_ctrl !== 12'h0) begin bad++; $display("FAIL lat_retire: got %b %h want 0 000", out_valid, out_ctrl); end
    endtask

    task automatic test_fill();
        int exp_cnt [6] = '{4, 3, 3, 2, 1, 0};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_pc   = fpc(i);
            in_inst = finst(i);
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_%0d: got %b want 1", i, in_ready); end
            step();
        end
        in_pc   = fpc(5);
        in_inst = finst(5);
        total++; if (count !== 3'd4 || in_ready !== 1'b0) begin bad++; $display("FAIL fill_full: got count=%0d ready=%b want 4 0", count, in_ready); end
        total++; if (out_valid !== 1'b1 || out_pc !== fpc(0)) begin bad++; $display("FAIL fill_staged: got %b %h want 1 %h", out_valid, out_pc, fpc(0)); end
        step();
        step();
        total++; if (count !== 3'd4 || in_ready !== 1'b0 || out_pc !== fpc(0)) begin bad++; $display("FAIL fill_hold: got count=%0d ready=%b pc=%h want 4 0 %h", count, in_ready, out_pc, fpc(0)); end
        out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            total++; if (out_valid !== 1'b1 || out_pc !== fpc(j) || out_inst !== finst(j)) begin bad++; $display("FAIL drain_order_%0d: got %b %h %h want 1 %h %h", j, out_valid, out_pc, out_inst, fpc(j), finst(j)); end
            total++; if (count !== 3'(exp_cnt[j])) begin bad++; $display("FAIL drain_count_%0d: got %0d want %0d", j, count, exp_cnt[j]); end
            if (j == 2) in_valid = 1'b0;
            step();
        end
        total++; if (out_valid !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL drain_empty: got %b %0d want 0 0", out_valid, count); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_pc   = 32'h400 + 32'(4 * i);
            in_inst = finst(i);
            step();
            if (i >= 1) begin
                total++; if (count !== 3'd1 || out_valid !== 1'b1 || out_pc !== 32'h400 + 32'(4 * (i - 1))) begin bad++; $display("FAIL b2b_%0d: got count=%0d valid=%b pc=%h want 1 1 %h", i, count, out_valid, out_pc, 32'h400 + 32'(4 * (i - 1))); end
            end
        end
        in_valid = 1'b0;
        step();
        total++; if (out_pc !== 32'h44c || count !== 3'd0 || out_valid !== 1'b1) begin bad++; $display("FAIL b2b_last: got %h %0d %b want 44c 0 1", out_pc, count, out_valid); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h500;
        in_inst   = I_BEQ;
        step();
        for (int i = 1; i <= 3; i++) begin
            in_pc   = 32'h500 + 32'(4 * i);
            in_inst = finst(i);
            step();
        end
        total++; if (count !== 3'd3 || out_valid !== 1'b1 || out_ctrl !== 12'h080 || out_pc !== 32'h500) begin bad++; $display("FAIL flush_setup: got count=%0d valid=%b ctrl=%h pc=%h want 3 1 080 500", count, out_valid, out_ctrl, out_pc); end
        in_pc   = 32'h600;
        in_inst = finst(9);
        flush   = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        total++; if (count !== 3'd0 || out_valid !== 1'b0 || out_ctrl !== 12'h0) begin bad++; $display("FAIL flush_clear: got count=%0d valid=%b ctrl=%h want 0 0 000", count, out_valid, out_ctrl); end
        step();
        step();
        total++; if (count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped: got count=%0d valid=%b want 0 0", count, out_valid); end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h700;
        in_inst   = I_ADDI;
        step();
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h700 || out_inst !== I_ADDI) begin bad++; $display("FAIL flush_recover: got %b %h %h want 1 700 %h", out_valid, out_pc, out_inst, I_ADDI); end
        step();
    endtask

    task automatic test_wfi();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc = 32'h800; in_inst = I_WFI;    step();
        in_pc = 32'h804; in_inst = finst(1); step();
        in_pc = 32'h808; in_inst = finst(2); step();
        in_valid = 1'b0;
        total++; if (out_ctrl !== 12'h500 || out_aluop !== 2'b00 || count !== 3'd2) begin bad++; $display("FAIL wfi_decode: got ctrl=%h aluop=%b count=%0d want 500 00 2", out_ctrl, out_aluop, count); end
        out_ready = 1'b1;
        step();
        total++; if (wfi_sleep !== 1'b1 || out_valid !== 1'b1 || out_pc !== 32'h804 || count !== 3'd1) begin bad++; $display("FAIL wfi_enter: got sleep=%b valid=%b pc=%h count=%0d want 1 1 804 1", wfi_sleep, out_valid, out_pc, count); end
        step();
        for (int i = 0; i < 10; i++) begin
            total++; if (wfi_sleep !== 1'b1 || out_valid !== 1'b0 || count !== 3'd1) begin bad++; $display("FAIL wfi_hold_%0d: got sleep=%b valid=%b count=%0d want 1 0 1", i, wfi_sleep, out_valid, count); end
            step();
        end
        irq_pending = 1'b1;
        step();
        total++; if (wfi_sleep !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL wfi_wake: got sleep=%b valid=%b want 0 0", wfi_sleep, out_valid); end
        step();
        irq_pending = 1'b0;
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h808 || count !== 3'd0) begin bad++; $display("FAIL wfi_resume: got valid=%b pc=%h count=%0d want 1 808 0", out_valid, out_pc, count); end
        step();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc = 32'h900; in_inst = I_WFI;    step();
        in_pc = 32'h904; in_inst = finst(3); step();
        in_valid    = 1'b0;
        irq_pending = 1'b1;
        out_ready   = 1'b1;
        step();
        total++; if (wfi_sleep !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h904) begin bad++; $display("FAIL wfi_irq_high: got sleep=%b valid=%b pc=%h want 0 1 904", wfi_sleep, out_valid, out_pc); end
        step();
        irq_pending = 1'b0;
        total++; if (wfi_sleep !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL wfi_irq_done: got sleep=%b valid=%b want 0 0", wfi_sleep, out_valid); end
    endtask

    task automatic test_decode();
        logic [31:0] insts [11] = '{32'h0020a023, 32'h0000a103, 32'h008000ef, 32'h30200073,
                                    32'h123450b7, 32'h00000000, 32'h002081b3, 32'h00208463,
                                    32'h000080e7, 32'h00001097, 32'h30529073};
        logic [11:0] ctrls [11] = '{12'h00A, 12'h016, 12'h0C5, 12'h600, 12'h005, 12'h806,
                                    12'h004, 12'h080, 12'h0A5, 12'h007, 12'h404};
        logic [1:0]  aluops [11] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00,
                                     2'b10, 2'b00, 2'b00, 2'b01, 2'b00};
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'hA00 + 32'(4 * i);
            in_inst  = insts[i];
            step();
            in_valid = 1'b0;
            step();
            total++; if (out_valid !== 1'b1 || out_ctrl !== ctrls[i] || out_aluop !== aluops[i]) begin bad++; $display("FAIL decode_%h: got valid=%b ctrl=%h aluop=%b want 1 %h %b", insts[i], out_valid, out_ctrl, out_aluop, ctrls[i], aluops[i]); end
            step();
        end
        total++; if (out_valid !== 1'b0 || out_ctrl !== 12'h0 || out_aluop !== 2'b00) begin bad++; $display("FAIL decode_idle: got %b %h %b want 0 000 00", out_valid, out_ctrl, out_aluop); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc = 32'hB00; in_inst = I_ADDI; step();
        in_pc = 32'hB04; step();
        in_pc = 32'hB08; step();
        in_valid = 1'b0;
        flush    = 1'b1;
        rst_n    = 1'b0;
        step();
        rst_n = 1'b1;
        flush = 1'b0;
        total++; if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0) begin bad++; $display("FAIL reset_mid: got count=%0d valid=%b pc=%h inst=%h want 0 0 0 0", count, out_valid, out_pc, out_inst); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill();
        test_back_to_back();
        test_flush();
        test_wfi();
        test_decode();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
